// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers, imported by the sync generator and the
// pixel generator so both agree on screen bounds.
package vga_timing_pkg;

   localparam int unsigned COORD_W = 10;

   localparam int unsigned H_DISP  = 640;
   localparam int unsigned H_FP    = 16;
   localparam int unsigned H_SYNC  = 96;
   localparam int unsigned H_BP    = 48;
   localparam int unsigned V_DISP  = 480;
   localparam int unsigned V_FP    = 10;
   localparam int unsigned V_SYNC  = 2;
   localparam int unsigned V_BP    = 33;

   localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

   typedef logic [COORD_W-1:0] coord_t;

   // Half-open range test; zero-extends so an upper bound of 1024 still works.
   function automatic logic in_range(coord_t v, int unsigned lo, int unsigned hi);
      return (32'(v) >= lo) && (32'(v) < hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: scan position, sync levels and strobes from the sync generator.
interface vga_sync_gen_if;

   logic                   p_tick;
   vga_timing_pkg::coord_t pixel_x;
   vga_timing_pkg::coord_t pixel_y;
   logic                   video_on;
   logic                   hsync;
   logic                   vsync;
   logic                   refr_tick;

   modport master (
      output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, refr_tick
   );

   modport slave (
      input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, refr_tick
   );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Mod-CLK_DIV clock divider producing the registered one-clk pixel tick.
module pixel_tick_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic p_tick_o,
   output logic wrap_o
);

   localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            p_tick_q, p_tick_d;
   logic            wrap;

   always_comb begin
      wrap     = (cnt_q == CntW'(CLK_DIV - 1));
      cnt_d    = wrap ? '0 : cnt_q + CntW'(1);
      p_tick_d = wrap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         p_tick_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         p_tick_q <= p_tick_d;
      end
   end

   assign p_tick_o = p_tick_q;
   assign wrap_o   = wrap;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, H/V scan counters and registered sync,
// blanking and per-frame refresh strobes.
module vga_sync_gen #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_DISP   = vga_timing_pkg::H_DISP,
   parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
   parameter int unsigned V_DISP   = vga_timing_pkg::V_DISP,
   parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
   parameter bit          SYNC_ACT = 1'b0
) (
   input logic                  clk,
   input logic                  rst,
   vga_sync_gen_if.master       vga
);

   import vga_timing_pkg::*;

   localparam int unsigned H_TOT    = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT    = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_DISP + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_DISP + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   if (H_TOT > (1 << COORD_W) || V_TOT > (1 << COORD_W) || CLK_DIV < 1) begin : g_bad_cfg
      $error("vga_sync_gen: timing does not fit the coordinate width or CLK_DIV < 1");
   end

   logic   adv;
   logic   p_tick;
   coord_t x_q, x_d, y_q, y_d;
   logic   vo_q, vo_d, hs_q, hs_d, vs_q, vs_d, rt_q, rt_d;

   pixel_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .p_tick_o (p_tick),
      .wrap_o   (adv)
   );

   // Counters step on the same edge that raises p_tick, so p_tick marks the first
   // clk of each new pixel; decodes use the next-state position to stay aligned.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (adv) begin
         if (x_q == coord_t'(H_TOT - 1)) begin
            x_d = '0;
            y_d = (y_q == coord_t'(V_TOT - 1)) ? '0 : y_q + coord_t'(1);
         end else begin
            x_d = x_q + coord_t'(1);
         end
      end
      vo_d = in_range(x_d, 0, H_DISP) && in_range(y_d, 0, V_DISP);
      hs_d = in_range(x_d, HS_START, HS_END) ? SYNC_ACT : ~SYNC_ACT;
      vs_d = in_range(y_d, VS_START, VS_END) ? SYNC_ACT : ~SYNC_ACT;
      rt_d = adv && (x_d == '0) && (32'(y_d) == V_DISP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q  <= '0;
         y_q  <= '0;
         vo_q <= 1'b1;
         hs_q <= ~SYNC_ACT;
         vs_q <= ~SYNC_ACT;
         rt_q <= 1'b0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         vo_q <= vo_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         rt_q <= rt_d;
      end
   end

   assign vga.p_tick    = p_tick;
   assign vga.pixel_x   = x_q;
   assign vga.pixel_y   = y_q;
   assign vga.video_on  = vo_q;
   assign vga.hsync     = hs_q;
   assign vga.vsync     = vs_q;
   assign vga.refr_tick = rt_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Video timing generator that drives the VGA connector and feeds the pong pixel generator.
- Divides the system clock down to a pixel-rate enable and runs horizontal and vertical scan counters.
- Outputs hsync/vsync, video_on, the current pixel coordinates and a once-per-frame refr_tick. The pixel generator uses refr_tick to step ball and paddle animation.
- Default timing is 640x480 @ 60 Hz from a 100 MHz clk (25 MHz pixel rate).

Parameters:
- CLK_DIV, 4, clk cycles per pixel (>=1).
- H_DISP, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_DISP, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_ACT, 0, active level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- p_tick  out  1  one-clk pulse, once every CLK_DIV clk cycles; counters advance on it.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- video_on  out  1  1 when pixel_x<H_DISP and pixel_y<V_DISP.
- hsync  out  1  horizontal sync, level per SYNC_ACT.
- vsync  out  1  vertical sync, level per SYNC_ACT.
- refr_tick  out  1  one-clk pulse at start of vertical blank.

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).
- Reset (async, immediate):
  - div counter = 0, pixel_x = 0, pixel_y = 0, p_tick = 0, refr_tick = 0.
  - video_on = 1 (consistent with position 0,0).
  - hsync = vsync = inactive (~SYNC_ACT).
- Divider: a mod-CLK_DIV counter. p_tick is registered and high for exactly 1 clk when the counter wraps.
  - First p_tick is in clk cycle CLK_DIV after reset release.
  - CLK_DIV=1 gives p_tick constantly high.
- Scan counters update on the clk edge where p_tick=1:
  - pixel_x increments. At pixel_x==H_TOTAL-1 it wraps to 0 and pixel_y increments.
  - pixel_y wraps to 0 when it is V_TOTAL-1 and pixel_x wraps.
  - Counters never exceed H_TOTAL-1 / V_TOTAL-1.
- All of hsync, vsync, video_on and refr_tick are registered from the next-state counter values. They are therefore always the exact function of the currently displayed pixel_x/pixel_y, with zero skew and no combinational glitching.
- hsync is active iff H_DISP+H_FP <= pixel_x < H_DISP+H_FP+H_SYNC (656..751).
- vsync is active iff V_DISP+V_FP <= pixel_y < V_DISP+V_FP+V_SYNC (490..491).
- video_on = (pixel_x<H_DISP) && (pixel_y<V_DISP).
- refr_tick is high for exactly the single clk cycle in which (pixel_x,pixel_y) first becomes (0,V_DISP).
  - This gives exactly one pulse per frame, period H_TOTAL*V_TOTAL*CLK_DIV clk.
  - It is not repeated for the other CLK_DIV-1 cycles of that pixel.
- Between p_ticks all outputs hold.
- Reset asserted mid-frame returns every output to its reset value immediately. No partial sync pulse is extended: hsync/vsync go inactive at once. Timing restarts from (0,0) after release.
- Widths: counters are 10-bit unsigned. H_TOTAL and V_TOTAL must be <=1024; this is a static check in elaboration.

Decomposition:
- Shared package vga_timing_pkg holds:
  - default timing constants: H_DISP, H_FP, H_SYNC, H_BP, V_DISP, V_FP, V_SYNC, V_BP;
  - derived H_TOTAL/V_TOTAL;
  - the coordinate width constant (10).
- The pixel generator imports the same package so that its screen bounds match.
- One sub-module, pixel_tick_div: the parameterised mod-CLK_DIV counter producing p_tick.

Test Plan:
- Reset release, CLK_DIV=4 -> p_tick every 4 clk, first at cycle 4; pixel_x reaches 1 at cycle 4; pixel_x wraps 799->0 and pixel_y 0->1 after 3200 clk.
- Run one line -> hsync active-low for exactly 384 clk, starting when pixel_x becomes 656 and ending when it becomes 752; video_on falls when pixel_x becomes 640 and rises when it returns to 0.
- Run full frame -> vsync low exactly 2 lines (6400 clk) starting at pixel_y=490; video_on stays 0 for all of pixel_y 480..524; pixel_y wraps 524->0 after 1,680,000 clk.
- Run three frames -> refr_tick pulses exactly once per frame, 1 clk wide, coincident with (pixel_x=0, pixel_y=480); first at clk 1,536,000 after release; spacing 1,680,000 clk.
- Assert rst during hsync pulse at pixel (700,300) -> same cycle: hsync=vsync=1, pixel_x=pixel_y=0, refr_tick=0; after release, timing identical to the first scenario.
- CLK_DIV=1, small timing (H 8/1/2/1, V 4/1/1/1) -> p_tick stays 1; hsync at x=9..10; refr_tick at (0,4) every 84 clk.
